// File: rtl/frame_buf_reader.sv
// Streams a frame of words out of a 512x16 synchronous-read sample buffer
// into a valid/ready stream, with a 2-entry output FIFO absorbing consumer stalls.
module frame_buf_reader #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   frame_len,
  output logic [ADDR_W-1:0] adb,
  output logic              ceb,
  output logic              oce,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  iss_left_q, iss_left_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              head_valid_q, head_valid_d;
  logic              head_last_q, head_last_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic              skid_last_q, skid_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [LEN_W-1:0]  len_c;
  logic              beat_c;
  logic [1:0]        occ_c;
  logic              issue_c;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_valid, b_valid, a_last, b_last;

  // Issue gating: words held next cycle (after this beat) plus the new read must fit in 2 entries.
  always_comb begin
    len_c   = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
    beat_c  = head_valid_q & m_ready;
    occ_c   = 2'(head_valid_q) + 2'(skid_valid_q) + 2'(infl_q) - 2'(beat_c);
    issue_c = (state_q == S_READ) && (iss_left_q != '0) && (occ_c < 2'd2);
  end

  // Output FIFO: pop the head on a beat, then append the word returning from the buffer.
  always_comb begin
    a_valid = beat_c ? skid_valid_q : head_valid_q;
    a_data  = beat_c ? skid_data_q  : head_data_q;
    a_last  = beat_c ? skid_last_q  : head_last_q;
    b_valid = beat_c ? 1'b0 : skid_valid_q;
    b_data  = skid_data_q;
    b_last  = skid_last_q;
    if (infl_q) begin
      if (!a_valid) begin
        a_valid = 1'b1;
        a_data  = dout;
        a_last  = infl_last_q;
      end else begin
        b_valid = 1'b1;
        b_data  = dout;
        b_last  = infl_last_q;
      end
    end
    head_valid_d = a_valid;
    head_data_d  = a_data;
    head_last_d  = a_last;
    skid_valid_d = b_valid;
    skid_data_d  = b_data;
    skid_last_d  = b_last;
  end

  // Frame sequencing and read issue.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    iss_left_d  = iss_left_q;
    infl_d      = issue_c;
    infl_last_d = issue_c && (iss_left_q == LEN_W'(1));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d      = start_addr;
          iss_left_d = len_c;
          state_d    = (len_c == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        if (issue_c) begin
          ptr_d      = ptr_q + ADDR_W'(1);
          iss_left_d = iss_left_q - LEN_W'(1);
          if (iss_left_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (beat_c && head_last_q) state_d = S_FIN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      iss_left_q   <= '0;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
      head_data_q  <= '0;
      head_valid_q <= 1'b0;
      head_last_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      iss_left_q   <= iss_left_d;
      infl_q       <= infl_d;
      infl_last_q  <= infl_last_d;
      head_data_q  <= head_data_d;
      head_valid_q <= head_valid_d;
      head_last_q  <= head_last_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // The read enable must see the current beat to sustain one word per cycle.
  assign adb     = ptr_q;
  assign ceb     = issue_c;
  assign oce     = 1'b1;
  assign m_data  = head_data_q;
  assign m_valid = head_valid_q;
  assign m_last  = head_last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_frame_buf_reader.sv
// Bench for frame_buf_reader: buffer model, frame scoreboard built from address
// arithmetic, table of frame configurations, and hand-timed corner sequences.
module tb_frame_buf_reader;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;

  logic          clk, rst_n, start;
  logic [AW-1:0] start_addr, adb;
  logic [AW:0]   frame_len;
  logic          ceb, oce;
  logic [DW-1:0] dout, m_data;
  logic          m_valid, m_ready, m_last, busy, done;

  frame_buf_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .frame_len(frame_len), .adb(adb), .ceb(ceb), .oce(oce), .dout(dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  logic [DW-1:0] mem [512];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read buffer: data valid one cycle after an enabled edge.
  always @(posedge clk) if (ceb) dout <= mem[adb];

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct {
    logic [AW-1:0] sa; logic [AW:0] fl; int mode; int lo; int hi; bit dup_start; int exp_beats;
  } vec_t;

  beat_t         exp_beat_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int n_checks = 0, n_pass = 0;
  int issued_cnt = 0, beats_cnt = 0, done_cnt = 0;
  bit done_prev = 0, hold_q = 0;
  logic [DW-1:0] held_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Expected frame: consecutive buffer words modulo 512, length clipped to 512.
  task automatic load_expect(input logic [AW-1:0] sa, input logic [AW:0] fl, output int n);
    beat_t b;
    logic [AW-1:0] a;
    n = (int'(fl) > 512) ? 512 : int'(fl);
    for (int i = 0; i < n; i++) begin
      a = AW'(int'(sa) + i);
      exp_addr_q.push_back(a);
      b.data = mem[a];
      b.last = (i == n - 1);
      exp_beat_q.push_back(b);
    end
  endtask

  task automatic monitor();
    beat_t e;
    logic [AW-1:0] a;
    if (ceb) begin
      chk("issue_expected", 32'(exp_addr_q.size() > 0), 32'd1);
      if (exp_addr_q.size() > 0) begin
        a = exp_addr_q.pop_front();
        chk("adb", 32'(adb), 32'(a));
      end
      issued_cnt++;
    end
    if (hold_q) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(held_data));
    end
    if (m_valid && m_ready) begin
      chk("beat_expected", 32'(exp_beat_q.size() > 0), 32'd1);
      if (exp_beat_q.size() > 0) begin
        e = exp_beat_q.pop_front();
        chk("m_data", 32'(m_data), 32'(e.data));
        chk("m_last", 32'(m_last), 32'(e.last));
      end
      beats_cnt++;
    end
    if (busy) chk("buffered_le_2", 32'((issued_cnt - beats_cnt) <= 2), 32'd1);
    if (done) begin
      chk("done_single", 32'(done_prev), 32'd0);
      done_cnt++;
    end
    done_prev = done;
    hold_q    = m_valid && !m_ready;
    held_data = m_data;
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, output int nb);
    int n, j, b0, d0;
    load_expect(v.sa, v.fl, n);
    b0 = beats_cnt;
    d0 = done_cnt;
    start = 1'b1; start_addr = v.sa; frame_len = v.fl; m_ready = 1'b1;
    sample(); adv();
    start = 1'b0; start_addr = AW'($urandom); frame_len = (AW+1)'($urandom);
    j = 0;
    while (done_cnt == d0 && j < 3000) begin
      case (v.mode)
        0:       m_ready = 1'b1;
        1:       m_ready = !(j >= v.lo && j <= v.hi);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      start = v.dup_start && (j == 5);
      sample(); adv();
      j++;
    end
    start = 1'b0; m_ready = 1'b1;
    nb = beats_cnt - b0;
    chk("frame_done", 32'(done_cnt - d0), 32'd1);
    chk("beat_count", 32'(nb), 32'(n));
    chk("exp_left", 32'(exp_beat_q.size() + exp_addr_q.size()), 32'd0);
    exp_beat_q.delete(); exp_addr_q.delete();
    issued_cnt = beats_cnt;
    sample();
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    adv();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_last"},  32'(m_last),  32'd0);
    chk({tag, "_busy"},    32'(busy),    32'd0);
    chk({tag, "_done"},    32'(done),    32'd0);
    chk({tag, "_ceb"},     32'(ceb),     32'd0);
    chk({tag, "_adb"},     32'(adb),     32'd0);
    chk({tag, "_m_data"},  32'(m_data),  32'd0);
    chk({tag, "_oce"},     32'(oce),     32'd1);
  endtask

  initial begin
    vec_t tbl[9];
    vec_t rv;
    int n, nb, j, b0, d0;
    int e_ceb[8], e_val[8];

    tbl[0] = '{sa: 9'd0,   fl: 10'd4,   mode: 0, lo: 0, hi: 0,  dup_start: 0, exp_beats: 4};
    tbl[1] = '{sa: 9'd510, fl: 10'd4,   mode: 0, lo: 0, hi: 0,  dup_start: 0, exp_beats: 4};
    tbl[2] = '{sa: 9'd40,  fl: 10'd8,   mode: 1, lo: 3, hi: 7,  dup_start: 0, exp_beats: 8};
    tbl[3] = '{sa: 9'd37,  fl: 10'd600, mode: 0, lo: 0, hi: 0,  dup_start: 1, exp_beats: 512};
    tbl[4] = '{sa: 9'd300, fl: 10'd1,   mode: 0, lo: 0, hi: 0,  dup_start: 0, exp_beats: 1};
    tbl[5] = '{sa: 9'd5,   fl: 10'd512, mode: 2, lo: 0, hi: 0,  dup_start: 0, exp_beats: 512};
    tbl[6] = '{sa: 9'd200, fl: 10'd0,   mode: 0, lo: 0, hi: 0,  dup_start: 0, exp_beats: 0};
    tbl[7] = '{sa: 9'd500, fl: 10'd30,  mode: 1, lo: 0, hi: 12, dup_start: 0, exp_beats: 30};
    tbl[8] = '{sa: 9'd9,   fl: 10'd513, mode: 0, lo: 0, hi: 0,  dup_start: 0, exp_beats: 512};
    e_ceb = '{1, 1, 1, 1, 0, 0, 0, 0};
    e_val = '{0, 0, 1, 1, 1, 1, 0, 0};

    for (int i = 0; i < 512; i++) mem[i] = DW'($urandom);
    rst_n = 1'b0; start = 1'b0; start_addr = '0; frame_len = '0; m_ready = 1'b1;
    #1;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    adv();

    // Nominal 4-word frame, cycle by cycle from the start edge.
    load_expect(9'd0, 10'd4, n);
    d0 = done_cnt;
    start = 1'b1; start_addr = 9'd0; frame_len = 10'd4;
    sample(); adv();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sample();
      chk("t_ceb", 32'(ceb), 32'(e_ceb[k]));
      if (k < 4) chk("t_adb", 32'(adb), 32'(k));
      chk("t_m_valid", 32'(m_valid), 32'(e_val[k]));
      chk("t_m_last", 32'(m_last), 32'(k == 5));
      chk("t_done", 32'(done), 32'(k == 6));
      chk("t_busy", 32'(busy), 32'(k < 7));
      adv();
    end
    chk("t_done_count", 32'(done_cnt - d0), 32'd1);
    chk("t_exp_left", 32'(exp_beat_q.size() + exp_addr_q.size()), 32'd0);

    // Zero-length frame: one busy cycle carrying the done pulse.
    start = 1'b1; start_addr = 9'd77; frame_len = 10'd0;
    sample(); adv();
    start = 1'b0;
    sample();
    chk("z_busy", 32'(busy), 32'd1);
    chk("z_done", 32'(done), 32'd1);
    chk("z_ceb", 32'(ceb), 32'd0);
    chk("z_m_valid", 32'(m_valid), 32'd0);
    adv();
    sample();
    chk("z_busy_end", 32'(busy), 32'd0);
    chk("z_done_end", 32'(done), 32'd0);
    adv();

    for (int i = 0; i < 9; i++) begin
      run_frame(tbl[i], nb);
      chk("tbl_beats", 32'(nb), 32'(tbl[i].exp_beats));
    end

    // Reset after the third beat abandons the frame without done.
    load_expect(9'd100, 10'd20, n);
    start = 1'b1; start_addr = 9'd100; frame_len = 10'd20; m_ready = 1'b1;
    sample(); adv();
    start = 1'b0;
    b0 = beats_cnt; d0 = done_cnt; j = 0;
    while (beats_cnt - b0 < 3 && j < 40) begin
      sample();
      if (beats_cnt - b0 < 3) adv();
      j++;
    end
    chk("r_three_beats", 32'(beats_cnt - b0), 32'd3);
    chk("r_valid_before", 32'(m_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid");
    exp_beat_q.delete(); exp_addr_q.delete();
    issued_cnt = beats_cnt; done_prev = 0; hold_q = 0;
    repeat (3) begin
      @(negedge clk);
      chk("r_done_in_reset", 32'(done), 32'd0);
    end
    chk("r_no_done", 32'(done_cnt - d0), 32'd0);
    adv();
    rst_n = 1'b1;
    adv();
    rv = '{sa: 9'd0, fl: 10'd2, mode: 0, lo: 0, hi: 0, dup_start: 0, exp_beats: 2};
    run_frame(rv, nb);
    chk("r_after_beats", 32'(nb), 32'd2);

    // Randomized frames against the address-arithmetic model.
    for (int i = 0; i < 25; i++) begin
      rv.sa = AW'($urandom);
      rv.fl = ($urandom_range(0, 9) == 0) ? (AW+1)'($urandom_range(0, 1023))
                                          : (AW+1)'($urandom_range(0, 40));
      rv.mode = 2; rv.lo = 0; rv.hi = 0; rv.dup_start = 0;
      rv.exp_beats = (int'(rv.fl) > 512) ? 512 : int'(rv.fl);
      run_frame(rv, nb);
      chk("rand_beats", 32'(nb), 32'(rv.exp_beats));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_buf_reader.md
FRAME_BUF_READER -- requirements
Module: frame_buf_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, read-port address width of the 512x16 sample buffer.
REQ-002 SHALL have parameter DATA_W, default 16, sample width.
REQ-003 SHALL have port clk  in  1  single clock; the buffer read port and all logic run on it.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle request to stream one frame.
REQ-006 SHALL have port start_addr  in  ADDR_W  first buffer word, sampled on the accepted start.
REQ-007 SHALL have port frame_len  in  ADDR_W+1  word count, sampled on the accepted start.
REQ-008 SHALL have port adb  out  ADDR_W  buffer read address.
REQ-009 SHALL have port ceb  out  1  buffer read clock enable.
REQ-010 SHALL have port oce  out  1  buffer output enable; tied high.
REQ-011 SHALL have port dout  in  DATA_W  buffer read data, valid exactly 1 cycle after a ceb-high edge.
REQ-012 SHALL have port m_data  out  DATA_W  stream sample.
REQ-013 SHALL have port m_valid  out  1  stream valid.
REQ-014 SHALL have port m_ready  in  1  stream ready from the consumer.
REQ-015 SHALL have port m_last  out  1  marks the final sample of a frame.
REQ-016 SHALL have port busy  out  1  frame in progress.
REQ-017 SHALL have port done  out  1  one-cycle pulse at frame completion.

Function
REQ-018 SHALL implement states IDLE, READ, DRAIN, FIN.
REQ-019 IDLE: start accepted only here; start while busy is ignored with no side effects.
REQ-020 An accepted start SHALL latch start_addr and len = min(frame_len, 512), then enter READ, or enter FIN when len=0.
REQ-021 READ: assert ceb for one cycle per word with adb = issue pointer; increment the pointer modulo 512, so 511 wraps to 0.
REQ-022 Issue SHALL occur only when the entry count plus the in-flight count is below 2, so a word already read is never lost.
REQ-023 Data captured from dout one cycle after issue SHALL enter a 2-entry output FIFO in order.
REQ-024 m_data/m_valid SHALL present the FIFO head; a beat transfers on m_valid and m_ready high on a rising clk edge.
REQ-025 m_valid, once high, SHALL hold with m_data stable until the beat transfers.
REQ-026 m_last SHALL be high exactly on beat number len of the frame.
REQ-027 After len issues, READ SHALL move to DRAIN; DRAIN moves to FIN on the clock edge where the last beat transfers.
REQ-028 FIN SHALL pulse done for one cycle, then return to IDLE; busy is high in READ, DRAIN and FIN.
REQ-029 With m_ready held high and no stall, throughput SHALL be 1 word/cycle; the first m_valid appears 2 cycles after the start edge.
REQ-030 A capture into the FIFO and a beat out of it in the same cycle SHALL leave the entry count unchanged.
REQ-031 ceb SHALL be low whenever not in READ; adb SHALL hold its last value when ceb is low.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, clear the FIFO and in-flight flag, and set m_valid=0, m_last=0, busy=0, done=0, ceb=0, adb=0, m_data=0.
REQ-033 Reset mid-frame SHALL abandon the frame with no done pulse; the next start after release behaves as from power-up.
REQ-034 oce SHALL be 1 in and out of reset.

Verification
REQ-035 start_addr=0, frame_len=4, m_ready=1 -> adb 0,1,2,3 on consecutive cycles; 4 beats; m_last on beat 4; done 1 cycle after that beat.
REQ-036 start_addr=510, frame_len=4 -> adb sequence 510,511,0,1; data order matches the preloaded buffer contents.
REQ-037 frame_len=8, m_ready low for cycles 3-7 -> ceb stalls with at most 2 words buffered; no duplicate or dropped sample; m_data stable while stalled.
REQ-038 frame_len=0 -> no ceb, no m_valid; busy for 1 cycle; done pulse.
REQ-039 frame_len=600 -> exactly 512 beats; a second start during the frame is ignored.
REQ-040 rst_n low mid-frame after 3 beats -> all outputs go to reset values immediately with no done; a later start_addr=0, frame_len=2 completes normally.
